// File: rtl/add_sub_pkg.sv
// Shared definitions for the add/sub/accumulate datapath.
//   op_e       : operation codes carried alongside each operand beat
//   SAT_MAXW   : widest accumulator sat_clamp can handle
//   sat_clamp  : clamps a signed value to the range of a w-bit two's complement
//                number and reports whether clamping happened
package add_sub_pkg;

  typedef enum logic [2:0] {
    OP_ADD      = 3'd0,
    OP_SUB      = 3'd1,
    OP_ACC_LOAD = 3'd2,
    OP_ACC_ADD  = 3'd3,
    OP_ACC_SUB  = 3'd4
  } op_e;

  localparam int SAT_MAXW = 32;

  // val is a sign-extended copy of a (w+1)-bit intermediate. The return value
  // is SAT_MAXW wide; callers keep only the low w bits.
  function automatic logic signed [SAT_MAXW-1:0] sat_clamp(
    input  logic signed [SAT_MAXW:0] val,
    input  int unsigned              w,
    output logic                     clamped
  );
    logic signed [SAT_MAXW:0]   lim;
    logic signed [SAT_MAXW:0]   hi;
    logic signed [SAT_MAXW:0]   lo;
    logic signed [SAT_MAXW-1:0] res;
    lim     = (SAT_MAXW + 1)'(1) <<< (w - 1);
    hi      = lim - (SAT_MAXW + 1)'(1);
    lo      = -lim;
    clamped = 1'b0;
    res     = val[SAT_MAXW-1:0];
    if (val > hi) begin
      res     = hi[SAT_MAXW-1:0];
      clamped = 1'b1;
    end else if (val < lo) begin
      res     = lo[SAT_MAXW-1:0];
      clamped = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/add_sub_acc_if.sv
// Stream bundle for add_sub_acc: an input beat channel (valid/ready with two
// operands and an op code) and an output result channel (valid/ready with
// result, per-result saturation flag and the sticky saturation flag).
//   slave  : the arithmetic unit's view
//   master : the producer/consumer (test environment) view
interface add_sub_acc_if #(
  parameter int DATAW = 4,
  parameter int ACCW  = 6
);
  logic             i_in_valid;
  logic             o_in_ready;
  logic [DATAW-1:0] i_dataa;
  logic [DATAW-1:0] i_datab;
  logic [2:0]       i_op;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [ACCW-1:0]  o_result;
  logic             o_sat;
  logic             o_sat_sticky;

  modport slave (
    input  i_in_valid, i_dataa, i_datab, i_op, i_out_ready,
    output o_in_ready, o_out_valid, o_result, o_sat, o_sat_sticky
  );

  modport master (
    output i_in_valid, i_dataa, i_datab, i_op, i_out_ready,
    input  o_in_ready, o_out_valid, o_result, o_sat, o_sat_sticky
  );
endinterface

// File: rtl/add_sub_core.sv
// Combinational W-bit signed adder/subtractor with an exact (W+1)-bit result.
//   i_a, i_b : signed operands
//   i_sub    : 1 -> i_a - i_b (B inverted, carry-in 1); 0 -> i_a + i_b
//   o_sum    : signed W+1-bit result, never overflows
module add_sub_core #(
  parameter int W = 4
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  input  logic                i_sub,
  output logic signed [W:0]   o_sum
);

  logic signed [W:0] a_ext;
  logic signed [W:0] b_ext;

  // Sign-extend before inverting so ~B stays the correct two's complement
  // complement at W+1 bits.
  assign a_ext = {i_a[W-1], i_a};
  assign b_ext = i_sub ? ~{i_b[W-1], i_b} : {i_b[W-1], i_b};
  assign o_sum = a_ext + b_ext + (W + 1)'(i_sub);

endmodule

// File: rtl/add_sub_acc.sv
// Two-stage pipelined signed add/sub unit with a saturating accumulator.
//   clk, rst : clock and synchronous active-high reset
//   bus      : add_sub_acc_if.slave stream bundle
//     input beat  : i_in_valid/o_in_ready, i_dataa, i_datab, i_op
//     output beat : o_out_valid/i_out_ready, o_result, o_sat, o_sat_sticky
// S1 registers the accepted operands; the operation is evaluated when S1
// moves into S2 (the output register). acc and the sticky flag change only on
// that transfer, so stalls never disturb accumulator state.
module add_sub_acc
  import add_sub_pkg::*;
#(
  parameter int DATAW = 4,
  parameter int ACCW  = 6
) (
  input logic         clk,
  input logic         rst,
  add_sub_acc_if.slave bus
);

  // S1: input register
  logic                    s1_valid_q, s1_valid_d;
  logic signed [DATAW-1:0] a_q, a_d;
  logic signed [DATAW-1:0] b_q, b_d;
  logic [2:0]              op_q, op_d;

  // S2: output register
  logic                    out_valid_q, out_valid_d;
  logic [ACCW-1:0]         result_q, result_d;
  logic                    sat_q, sat_d;

  // Accumulator state
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic                    sticky_q, sticky_d;

  logic                    s2_en;
  logic                    s1_en;
  op_e                     op_eff;

  logic signed [DATAW:0]   ab_sum;
  logic signed [ACCW-1:0]  a_ext;
  logic signed [ACCW:0]    acc_sum;
  logic signed [ACCW-1:0]  acc_sat;
  logic                    acc_clamped;

  // S2 can take a new value when empty or when its current value leaves;
  // S1 can take a new beat when empty or when it drains into S2.
  assign s2_en = !out_valid_q || bus.i_out_ready;
  assign s1_en = !s1_valid_q || s2_en;

  // Unassigned codes 5..7 behave as plain addition.
  always_comb begin
    op_eff = OP_ADD;
    if (op_q <= 3'd4) begin
      op_eff = op_e'(op_q);
    end
  end

  assign a_ext = ACCW'(a_q);

  add_sub_core #(.W(DATAW)) u_core_ab (
    .i_a   (a_q),
    .i_b   (b_q),
    .i_sub (op_eff == OP_SUB),
    .o_sum (ab_sum)
  );

  add_sub_core #(.W(ACCW)) u_core_acc (
    .i_a   (acc_q),
    .i_b   (a_ext),
    .i_sub (op_eff == OP_ACC_SUB),
    .o_sum (acc_sum)
  );

  always_comb begin
    acc_clamped = 1'b0;
    acc_sat     = ACCW'(sat_clamp((SAT_MAXW + 1)'(acc_sum), ACCW, acc_clamped));
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    sat_d       = sat_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;

    if (s1_en) begin
      s1_valid_d = bus.i_in_valid;
      if (bus.i_in_valid) begin
        a_d  = bus.i_dataa;
        b_d  = bus.i_datab;
        op_d = bus.i_op;
      end
    end

    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        case (op_eff)
          OP_ACC_LOAD: begin
            acc_d    = a_ext;
            result_d = a_ext;
            sat_d    = 1'b0;
            sticky_d = 1'b0;
          end
          OP_ACC_ADD, OP_ACC_SUB: begin
            acc_d    = acc_sat;
            result_d = acc_sat;
            sat_d    = acc_clamped;
            sticky_d = sticky_q | acc_clamped;
          end
          default: begin
            result_d = ACCW'(ab_sum);
            sat_d    = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sat_q       <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      sat_q       <= sat_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

  assign bus.o_in_ready   = s1_en;
  assign bus.o_out_valid  = out_valid_q;
  assign bus.o_result     = result_q;
  assign bus.o_sat        = sat_q;
  assign bus.o_sat_sticky = sticky_q;

endmodule

// File: tb/tb_add_sub_acc.sv
module tb_add_sub_acc;
  localparam int DATAW = 4;
  localparam int ACCW  = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_sub_acc_if #(.DATAW(DATAW), .ACCW(ACCW)) bus ();

  add_sub_acc #(.DATAW(DATAW), .ACCW(ACCW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int res;
    bit sat;
    bit sticky;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   got_res[$];
  bit   got_sat[$];
  int   m_acc    = 0;
  bit   m_sticky = 1'b0;
  bit   prev_stall = 1'b0;
  int   prev_res   = 0;
  bit   rnd_done   = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout, expected completion", name);
  endtask

  // Reference behaviour: plain integer arithmetic with a -32..31 clamp.
  function automatic exp_t model_step(input int op, input int a, input int b);
    exp_t e;
    int   t;
    e.sat = 1'b0;
    case (op)
      1: e.res = a - b;
      2: begin
        m_acc    = a;
        m_sticky = 1'b0;
        e.res    = a;
      end
      3, 4: begin
        t = (op == 3) ? m_acc + a : m_acc - a;
        if (t > 31) begin
          t = 31;
          e.sat = 1'b1;
        end else if (t < -32) begin
          t = -32;
          e.sat = 1'b1;
        end
        m_acc    = t;
        m_sticky = m_sticky | e.sat;
        e.res    = t;
      end
      default: e.res = a + b;
    endcase
    e.sticky = m_sticky;
    return e;
  endfunction

  // Single compare process: sampled on the falling edge, between active edges.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_acc      = 0;
      m_sticky   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_hold", int'(bus.o_out_valid), 1);
        check("stall_result_hold", int'($signed(bus.o_result)), prev_res);
      end
      if (bus.o_out_valid) begin
        check("out_has_pending", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check("result", int'($signed(bus.o_result)), exp_q[0].res);
          check("sat", int'(bus.o_sat), int'(exp_q[0].sat));
          check("sticky", int'(bus.o_sat_sticky), int'(exp_q[0].sticky));
          if (bus.i_out_ready) begin
            got_res.push_back(int'($signed(bus.o_result)));
            got_sat.push_back(bus.o_sat);
            void'(exp_q.pop_front());
          end
        end
      end
      if (bus.i_in_valid && bus.o_in_ready) begin
        exp_q.push_back(model_step(int'(bus.i_op), int'($signed(bus.i_dataa)),
                                   int'($signed(bus.i_datab))));
      end
      prev_stall = bus.o_out_valid && !bus.i_out_ready;
      prev_res   = int'($signed(bus.o_result));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and return just after the edge that captures it.
  task automatic send(input int op, input int a, input int b);
    int waited = 0;
    bus.i_in_valid = 1'b1;
    bus.i_op       = op[2:0];
    bus.i_dataa    = a[DATAW-1:0];
    bus.i_datab    = b[DATAW-1:0];
    @(negedge clk);
    while (!bus.o_in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.o_in_ready) fail("accept_timeout");
    @(posedge clk);
    #1;
    bus.i_in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (exp_q.size() != 0) fail("drain_timeout");
    idle(1);
  endtask

  task automatic expect_got(input string name, input int idx, input int res, input int sat);
    if (idx < got_res.size()) begin
      check(name, got_res[idx], res);
      check({name, "_sat"}, int'(got_sat[idx]), sat);
    end else begin
      fail(name);
    end
  endtask

  task automatic clear_got();
    got_res.delete();
    got_sat.delete();
  endtask

  initial begin
    rst              = 1'b1;
    bus.i_in_valid   = 1'b0;
    bus.i_out_ready  = 1'b0;
    bus.i_dataa      = '0;
    bus.i_datab      = '0;
    bus.i_op         = '0;
    idle(2);
    check("rst_out_valid", int'(bus.o_out_valid), 0);
    check("rst_result", int'(bus.o_result), 0);
    check("rst_sat", int'(bus.o_sat), 0);
    check("rst_sticky", int'(bus.o_sat_sticky), 0);
    rst = 1'b0;
    idle(1);
    check("rst_in_ready", int'(bus.o_in_ready), 1);

    // ADD latency: captured into S1 at one edge, valid after the next.
    bus.i_out_ready = 1'b1;
    clear_got();
    send(0, 7, 5);
    check("lat_not_yet", int'(bus.o_out_valid), 0);
    idle(1);
    check("lat_valid", int'(bus.o_out_valid), 1);
    check("add_bits", int'(bus.o_result), 12);
    check("add_sat", int'(bus.o_sat), 0);
    drain();

    // SUB, then prove acc was left at 0.
    clear_got();
    send(1, -8, 7);
    send(3, 0, 0);
    drain();
    expect_got("sub_res", 0, -15, 0);
    expect_got("acc_unchanged", 1, 0, 0);

    // LOAD 7 then four back-to-back ACC_ADD 7.
    clear_got();
    send(2, 7, 0);
    for (int i = 0; i < 4; i++) send(3, 7, 0);
    drain();
    expect_got("load7", 0, 7, 0);
    expect_got("accadd1", 1, 14, 0);
    expect_got("accadd2", 2, 21, 0);
    expect_got("accadd3", 3, 28, 0);
    expect_got("accadd_sat", 4, 31, 1);
    check("sticky_after_sat", int'(bus.o_sat_sticky), 1);
    send(0, 1, 1);
    drain();
    check("sticky_kept_by_add", int'(bus.o_sat_sticky), 1);

    // LOAD -8 then four ACC_SUB 7.
    clear_got();
    send(2, -8, 0);
    for (int i = 0; i < 4; i++) send(4, 7, 0);
    drain();
    expect_got("load_m8", 0, -8, 0);
    expect_got("accsub1", 1, -15, 0);
    expect_got("accsub2", 2, -22, 0);
    expect_got("accsub3", 3, -29, 0);
    expect_got("accsub_sat", 4, -32, 1);

    // Backpressure: downstream stalled while beats stream in.
    clear_got();
    bus.i_out_ready = 1'b0;
    send(0, 1, 2);
    send(0, 3, 3);
    check("bp_in_ready_low", int'(bus.o_in_ready), 0);
    check("bp_out_valid", int'(bus.o_out_valid), 1);
    check("bp_head", int'($signed(bus.o_result)), 3);
    idle(1);
    check("bp_in_ready_still_low", int'(bus.o_in_ready), 0);
    bus.i_out_ready = 1'b1;
    send(0, -8, -8);
    send(1, 7, -8);
    drain();
    expect_got("bp0", 0, 3, 0);
    expect_got("bp1", 1, 6, 0);
    expect_got("bp2", 2, -16, 0);
    expect_got("bp3", 3, 15, 0);

    // Reset while stalled with both stages full and sticky set.
    send(2, 7, 0);
    for (int i = 0; i < 4; i++) send(3, 7, 0);
    drain();
    bus.i_out_ready = 1'b0;
    send(0, 1, 1);
    send(0, 2, 2);
    check("pre_rst_valid", int'(bus.o_out_valid), 1);
    check("pre_rst_sticky", int'(bus.o_sat_sticky), 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("post_rst_valid", int'(bus.o_out_valid), 0);
    check("post_rst_result", int'(bus.o_result), 0);
    check("post_rst_sticky", int'(bus.o_sat_sticky), 0);
    bus.i_out_ready = 1'b1;
    clear_got();
    send(3, 3, 0);
    drain();
    expect_got("post_rst_accadd", 0, 3, 0);
    check("post_rst_count", got_res.size(), 1);

    // Randomized traffic with random downstream backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)) - 8,
               int'($urandom_range(0, 15)) - 8);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          bus.i_out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    bus.i_out_ready = 1'b1;
    drain();
    check("final_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
